pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the decode->execute pipeline register and the downstream execute/memory stages.
- Detects load-use hazards and requests a one-cycle NOP bubble into the decode/execute register.
- Times multi-cycle multiply/divide operations and the fence drain window.
- Converts exception/mret retirement into a one-cycle pipeline flush.
- Drives de_stall, exe_stall and fence_stall consumed by the decode/execute register and the PC logic.

Parameters:
FENCE_CYCLES, 4, total fence_stall cycles per fence (range 1..15)
MUL_LAT, 3, exe_stall cycles for a multiply (range 1..63)
DIV_LAT, 33, exe_stall cycles for a divide (range 1..63)

Ports:
clk  in  1  clock, all state updates on rising edge
cpurst  in  1  synchronous active-high reset
de_inst_valid  in  1  decode stage holds a real instruction
de_rs1addr  in  5  decode source register 1
de_rs2addr  in  5  decode source register 2
de_rs1_used  in  1  instruction in decode reads rs1
de_rs2_used  in  1  instruction in decode reads rs2
de_fence  in  1  decode holds a fence
ex_load  in  1  execute-stage instruction is a load
ex_wr_reg  in  1  execute-stage instruction writes rd
ex_wr_regindex  in  5  execute-stage rd
ex_MD_OP  in  1  execute-stage instruction is mul/div
ex_md_is_div  in  1  qualifies ex_MD_OP: 1=divide, 0=multiply
memacc_stall  in  1  memory stage busy
mem2wb_exp  in  1  exception retiring from the memory/writeback register
mem2wb_mret  in  1  mret retiring
de_stall  out  1  insert NOP into the decode/execute register, hold PC and the fetch/decode register
exe_stall  out  1  freeze the decode/execute register and earlier stages
fence_stall  out  1  hold PC
pipe_flush  out  1  kill all younger instructions
md_busy  out  1  MD_RUN state active

Behaviour:
Reset and state:
- States: IDLE, MD_RUN, FENCE_DRAIN.
- cpurst: state=IDLE, counters=0, all outputs 0 on the following cycle. Reset mid-MD or mid-fence aborts immediately.

Flush:
- flush_req = mem2wb_exp | mem2wb_mret.
- pipe_flush = flush_req, combinational, same cycle.
- On flush_req, next state=IDLE and counters clear. de_stall, exe_stall and fence_stall are forced 0 that cycle.

MD sequencing:
- In IDLE, when ex_MD_OP=1 and memacc_stall=0: load cnt with (ex_md_is_div ? DIV_LAT : MUL_LAT)-1, go to MD_RUN.
- exe_stall=1 combinationally in that entry cycle.
- In MD_RUN: exe_stall=1 and cnt decrements each cycle. When cnt==0, exe_stall=0 and state returns to IDLE.
- Total exe_stall cycles = LAT exactly. LAT=1 means the entry cycle only and MD_RUN is never entered.
- The MD counter keeps running during memacc_stall.

Fence sequencing:
- In IDLE, when de_fence=1 and de_inst_valid=1 and exe_stall=0: fence_stall=1 in that cycle.
- If FENCE_CYCLES>1, go to FENCE_DRAIN with fcnt=FENCE_CYCLES-2.
- In FENCE_DRAIN, fence_stall=1. fcnt decrements only while memacc_stall=0. Exit to IDLE after the cycle in which fcnt==0.
- A fence is not re-triggered while in FENCE_DRAIN.

Load-use hazard:
- de_stall = de_inst_valid & ex_load & ex_wr_reg & (ex_wr_regindex!=0) & ((de_rs1_used & rs1==rd) | (de_rs2_used & rs2==rd)).
- Masked to 0 when exe_stall=1 or memacc_stall=1, because the decode/execute register ignores bubbles while stalled.
- de_stall lasts one cycle: the bubble moves the load out of execute.

Priority: cpurst > flush > exe_stall (MD) > fence > de_stall.
- ex_MD_OP and de_fence in the same IDLE cycle: MD wins. The fence is taken once exe_stall drops, since the fence is still held in decode.

md_busy = (state==MD_RUN).

Optional Feature:
Macro: STALL_PERF_CNT_EN.
- Defined: adds outputs perf_lu_cnt[31:0], perf_md_cnt[31:0] and perf_fence_cnt[31:0]. Each increments by 1 every cycle its stall (de_stall, exe_stall, fence_stall) is 1. Each wraps at 2^32-1 -> 0 and resets to 0 on cpurst.
- Undefined: the ports and counters are absent, with no other behavioural change.

Decomposition:
- Shared package pipe_ctrl_pkg: state encoding (IDLE=2'd0, MD_RUN=2'd1, FENCE_DRAIN=2'd2), default latency constants, x0 register index constant.
- One sub-module, lu_hazard_cmp: purely combinational rs/rd compare producing the raw load-use hit. Masking and priority stay in the parent.

Test Plan:
1. ex_load=1, ex_wr_regindex=5; decode rs2=5 with rs2_used=1 -> de_stall=1 for exactly 1 cycle. Repeat with rd=0 -> de_stall stays 0.
2. ex_MD_OP=1, ex_md_is_div=0, MUL_LAT=3 -> exe_stall=1 for 3 consecutive cycles, md_busy=1 on cycles 2-3. Divide with DIV_LAT=33 -> 33 cycles.
3. de_fence=1 with FENCE_CYCLES=4 and memacc_stall pulsed for 2 cycles mid-drain -> fence_stall=1 for 6 cycles, then 0.
4. mem2wb_exp=1 on the 10th cycle of a divide -> pipe_flush=1 that cycle, exe_stall=0 that cycle, md_busy=0 the next cycle.
5. ex_MD_OP and de_fence asserted together -> 3 cycles of exe_stall, then 4 cycles of fence_stall.
6. cpurst asserted mid-FENCE_DRAIN -> all outputs 0 the next cycle, state IDLE. With STALL_PERF_CNT_EN defined, perf counters read 0.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings and default latencies for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    MD_RUN      = 2'd1,
    FENCE_DRAIN = 2'd2
  } stall_state_e;

  localparam int DEF_FENCE_CYCLES = 4;
  localparam int DEF_MUL_LAT      = 3;
  localparam int DEF_DIV_LAT      = 33;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-side signals seen by the stall sequencer; master = pipeline, slave = sequencer.
interface pipe_stall_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic       de_inst_valid;
  logic [4:0] de_rs1addr;
  logic [4:0] de_rs2addr;
  logic       de_rs1_used;
  logic       de_rs2_used;
  logic       de_fence;
  logic       ex_load;
  logic       ex_wr_reg;
  logic [4:0] ex_wr_regindex;
  logic       ex_MD_OP;
  logic       ex_md_is_div;
  logic       memacc_stall;
  logic       mem2wb_exp;
  logic       mem2wb_mret;
  logic       de_stall;
  logic       exe_stall;
  logic       fence_stall;
  logic       pipe_flush;
  logic       md_busy;

  modport master (
    output de_inst_valid, de_rs1addr, de_rs2addr, de_rs1_used, de_rs2_used, de_fence,
           ex_load, ex_wr_reg, ex_wr_regindex, ex_MD_OP, ex_md_is_div,
           memacc_stall, mem2wb_exp, mem2wb_mret,
    input  de_stall, exe_stall, fence_stall, pipe_flush, md_busy
  );

  modport slave (
    input  de_inst_valid, de_rs1addr, de_rs2addr, de_rs1_used, de_rs2_used, de_fence,
           ex_load, ex_wr_reg, ex_wr_regindex, ex_MD_OP, ex_md_is_div,
           memacc_stall, mem2wb_exp, mem2wb_mret,
    output de_stall, exe_stall, fence_stall, pipe_flush, md_busy
  );

endinterface

// File: rtl/pipe_stall_ctrl_lu_hazard_cmp.sv
// Raw load-use hit: a load in execute writes a register the decode instruction reads.
module lu_hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       de_inst_valid,
  input  logic [4:0] de_rs1addr,
  input  logic [4:0] de_rs2addr,
  input  logic       de_rs1_used,
  input  logic       de_rs2_used,
  input  logic       ex_load,
  input  logic       ex_wr_reg,
  input  logic [4:0] ex_wr_regindex,
  output logic       lu_hit
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = de_rs1_used && (de_rs1addr == ex_wr_regindex);
  assign rs2_hit = de_rs2_used && (de_rs2addr == ex_wr_regindex);
  assign lu_hit  = de_inst_valid && ex_load && ex_wr_reg &&
                   (ex_wr_regindex != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for decode->execute: load-use bubbles, mul/div and fence timing, flush.
// Optional STALL_PERF_CNT_EN adds per-stall cycle counters perf_lu_cnt/perf_md_cnt/perf_fence_cnt.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FENCE_CYCLES = DEF_FENCE_CYCLES,
  parameter int MUL_LAT      = DEF_MUL_LAT,
  parameter int DIV_LAT      = DEF_DIV_LAT
) (
  input  logic              clk,
  input  logic              cpurst,
  pipe_stall_ctrl_if.slave  pif
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_lu_cnt,
  output logic [31:0]       perf_md_cnt,
  output logic [31:0]       perf_fence_cnt
`endif
);

  localparam logic [5:0] MUL_LD   = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LD   = 6'(DIV_LAT - 1);
  localparam logic [3:0] FENCE_LD = 4'((FENCE_CYCLES > 1) ? (FENCE_CYCLES - 2) : 0);

  stall_state_e state;
  logic [5:0]   cnt;
  logic [3:0]   fcnt;

  logic       flush_req;
  logic       kill;
  logic       md_start;
  logic       fence_go;
  logic       lu_hit;
  logic       exe_stall_c;
  logic [5:0] lat_ld;

  lu_hazard_cmp u_lu_cmp (
    .de_inst_valid  (pif.de_inst_valid),
    .de_rs1addr     (pif.de_rs1addr),
    .de_rs2addr     (pif.de_rs2addr),
    .de_rs1_used    (pif.de_rs1_used),
    .de_rs2_used    (pif.de_rs2_used),
    .ex_load        (pif.ex_load),
    .ex_wr_reg      (pif.ex_wr_reg),
    .ex_wr_regindex (pif.ex_wr_regindex),
    .lu_hit         (lu_hit)
  );

  assign flush_req = pif.mem2wb_exp || pif.mem2wb_mret;
  assign kill      = cpurst || flush_req;
  assign lat_ld    = pif.ex_md_is_div ? DIV_LD : MUL_LD;

  // The MD entry cycle and the fence entry cycle stall combinationally, before state moves.
  assign md_start    = !kill && (state == IDLE) && pif.ex_MD_OP && !pif.memacc_stall;
  assign exe_stall_c = !kill && (md_start || (state == MD_RUN));
  assign fence_go    = !kill && (state == IDLE) && pif.de_fence && pif.de_inst_valid &&
                       !exe_stall_c;

  assign pif.pipe_flush  = !cpurst && flush_req;
  assign pif.exe_stall   = exe_stall_c;
  assign pif.fence_stall = !kill && (fence_go || (state == FENCE_DRAIN));
  assign pif.de_stall    = !kill && lu_hit && !exe_stall_c && !pif.memacc_stall;
  assign pif.md_busy     = (state == MD_RUN);

  always_ff @(posedge clk) begin
    if (cpurst || flush_req) begin
      state <= IDLE;
      cnt   <= '0;
      fcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            if (lat_ld != 6'd0) begin
              state <= MD_RUN;
              cnt   <= lat_ld;
            end
          end else if (fence_go && (FENCE_CYCLES > 1)) begin
            state <= FENCE_DRAIN;
            fcnt  <= FENCE_LD;
          end
        end
        MD_RUN: begin
          cnt <= (cnt == 6'd0) ? 6'd0 : cnt - 6'd1;
          if (cnt <= 6'd1) state <= IDLE;
        end
        FENCE_DRAIN: begin
          if (!pif.memacc_stall) begin
            if (fcnt == 4'd0) state <= IDLE;
            else              fcnt  <= fcnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (cpurst) begin
      perf_lu_cnt    <= '0;
      perf_md_cnt    <= '0;
      perf_fence_cnt <= '0;
    end else begin
      if (pif.de_stall)    perf_lu_cnt    <= perf_lu_cnt + 32'd1;
      if (pif.exe_stall)   perf_md_cnt    <= perf_md_cnt + 32'd1;
      if (pif.fence_stall) perf_fence_cnt <= perf_fence_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: stimulus queues expected outputs, a negedge monitor checks them.
module tb_pipe_stall_ctrl;

  localparam logic [4:0] DE = 5'b10000;
  localparam logic [4:0] EX = 5'b01000;
  localparam logic [4:0] FE = 5'b00100;
  localparam logic [4:0] PF = 5'b00010;
  localparam logic [4:0] MB = 5'b00001;
  localparam logic [4:0] NONE = 5'b00000;

  logic clk = 1'b0;
  logic cpurst;
  int   tests = 0;
  int   fails = 0;

  logic [4:0] exp_q[$];
  string      name_q[$];

  pipe_stall_ctrl_if pif ();

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_lu_cnt, perf_md_cnt, perf_fence_cnt;
`endif

  pipe_stall_ctrl #(.FENCE_CYCLES(4), .MUL_LAT(3), .DIV_LAT(33)) dut (
    .clk    (clk),
    .cpurst (cpurst),
    .pif    (pif)
`ifdef STALL_PERF_CNT_EN
    ,
    .perf_lu_cnt    (perf_lu_cnt),
    .perf_md_cnt    (perf_md_cnt),
    .perf_fence_cnt (perf_fence_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: outputs are settled mid-cycle, compare against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      logic [4:0] a;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {pif.de_stall, pif.exe_stall, pif.fence_stall, pif.pipe_flush, pif.md_busy};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got de/exe/fence/flush/busy=%b expected %b at %0t", n, a, e, $time);
      end
    end
  end

  task automatic cyc(input logic [4:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pif.de_inst_valid  = 1'b0;
    pif.de_rs1addr     = 5'd0;
    pif.de_rs2addr     = 5'd0;
    pif.de_rs1_used    = 1'b0;
    pif.de_rs2_used    = 1'b0;
    pif.de_fence       = 1'b0;
    pif.ex_load        = 1'b0;
    pif.ex_wr_reg      = 1'b0;
    pif.ex_wr_regindex = 5'd0;
    pif.ex_MD_OP       = 1'b0;
    pif.ex_md_is_div   = 1'b0;
    pif.memacc_stall   = 1'b0;
    pif.mem2wb_exp     = 1'b0;
    pif.mem2wb_mret    = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
    pif.de_inst_valid  = 1'b1;
    pif.ex_load        = 1'b1;
    pif.ex_wr_reg      = 1'b1;
    pif.ex_wr_regindex = rd;
    pif.de_rs1addr     = rs1;
    pif.de_rs2addr     = rs2;
    pif.de_rs1_used    = u1;
    pif.de_rs2_used    = u2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cpurst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    cyc(NONE, "reset_hold");
    cpurst = 1'b0;
    cyc(NONE, "idle_after_reset");

    // Load-use hazards
    set_load(5'd5, 5'd1, 5'd5, 1'b0, 1'b1);
    cyc(DE, "lu_rs2_hit");
    clear_inputs();
    cyc(NONE, "lu_bubble_done");
    set_load(5'd7, 5'd7, 5'd2, 1'b1, 1'b0);
    cyc(DE, "lu_rs1_hit");
    set_load(5'd7, 5'd7, 5'd7, 1'b0, 1'b0);
    cyc(NONE, "lu_unused_srcs");
    set_load(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cyc(NONE, "lu_rd_x0");
    set_load(5'd5, 5'd1, 5'd5, 1'b0, 1'b1);
    pif.memacc_stall = 1'b1;
    cyc(NONE, "lu_masked_memacc");
    clear_inputs();

    // Multiply: 3 cycles of exe_stall, md_busy on cycles 2-3
    pif.ex_MD_OP = 1'b1;
    cyc(EX, "mul_c1");
    pif.memacc_stall = 1'b1;
    cyc(EX | MB, "mul_c2_memacc");
    pif.memacc_stall = 1'b0;
    cyc(EX | MB, "mul_c3");
    pif.ex_MD_OP = 1'b0;
    cyc(NONE, "mul_done");

    pif.ex_MD_OP = 1'b1;
    pif.memacc_stall = 1'b1;
    cyc(NONE, "md_blocked_memacc");
    clear_inputs();

    // Divide: 33 cycles
    pif.ex_MD_OP = 1'b1;
    pif.ex_md_is_div = 1'b1;
    cyc(EX, "div_c1");
    for (int i = 2; i <= 33; i++) cyc(EX | MB, "div_run");
    clear_inputs();
    cyc(NONE, "div_done");

    // Fence with memacc_stall pulsed mid-drain: 6 cycles
    pif.de_fence = 1'b1;
    pif.de_inst_valid = 1'b1;
    cyc(FE, "fence_c1");
    cyc(FE, "fence_c2");
    pif.memacc_stall = 1'b1;
    cyc(FE, "fence_c3_memacc");
    cyc(FE, "fence_c4_memacc");
    pif.memacc_stall = 1'b0;
    cyc(FE, "fence_c5");
    cyc(FE, "fence_c6");
    pif.de_fence = 1'b0;
    cyc(NONE, "fence_done");
    clear_inputs();

    // Exception on 10th cycle of a divide
    pif.ex_MD_OP = 1'b1;
    pif.ex_md_is_div = 1'b1;
    cyc(EX, "divx_c1");
    for (int i = 2; i <= 9; i++) cyc(EX | MB, "divx_run");
    pif.mem2wb_exp = 1'b1;
    cyc(PF | MB, "divx_flush");
    clear_inputs();
    cyc(NONE, "divx_after_flush");
    pif.mem2wb_mret = 1'b1;
    cyc(PF, "mret_flush");
    clear_inputs();

    // MD and fence together: MD first, then fence
    pif.ex_MD_OP = 1'b1;
    pif.de_fence = 1'b1;
    pif.de_inst_valid = 1'b1;
    cyc(EX, "mdf_c1");
    cyc(EX | MB, "mdf_c2");
    cyc(EX | MB, "mdf_c3");
    pif.ex_MD_OP = 1'b0;
    for (int i = 0; i < 4; i++) cyc(FE, "mdf_fence");
    pif.de_fence = 1'b0;
    cyc(NONE, "mdf_done");
    clear_inputs();

    // Reset mid-drain aborts; a fresh fence afterwards runs its full length
    pif.de_fence = 1'b1;
    pif.de_inst_valid = 1'b1;
    cyc(FE, "rst_fence_c1");
    cyc(FE, "rst_fence_c2");
    cpurst = 1'b1;
    cyc(NONE, "rst_during_drain");
    cpurst = 1'b0;
    pif.de_fence = 1'b0;
    cyc(NONE, "after_rst");
`ifdef STALL_PERF_CNT_EN
    tests++;
    if (perf_lu_cnt !== 32'd0 || perf_md_cnt !== 32'd0 || perf_fence_cnt !== 32'd0) begin
      fails++;
      $display("FAIL perf_after_rst: got lu=%0d md=%0d fence=%0d expected all 0",
               perf_lu_cnt, perf_md_cnt, perf_fence_cnt);
    end
`endif
    pif.de_fence = 1'b1;
    for (int i = 0; i < 4; i++) cyc(FE, "post_rst_fence");
    pif.de_fence = 1'b0;
    cyc(NONE, "post_rst_fence_done");
    clear_inputs();

    @(negedge clk); #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
